// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the conv layer controller: FSM state encoding and
// the width of the weight address bus.
package conv_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/conv_ctrl_watchdog.sv
// Stall watchdog for the RUN phase: flags a timeout after TIMEOUT_CYCLES
// consecutive active cycles without a kick.
module conv_ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic kick,
  output logic timeout
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_reg;

  // The timeout fires during the Nth quiet cycle, so the FSM leaves RUN at its end.
  assign timeout = active && !kick && (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear || kick || !active) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/conv_ctrl.sv
// Conv layer controller: optional weight load from the host, then one frame run.
// Define CONV_CTRL_WATCHDOG_EN to enable the RUN stall watchdog and the error flag.
module conv_ctrl #(
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_BASE_ADDR = 23,
  parameter int WEIGHT_COUNT     = 224,
  parameter int OUT_PIXELS       = 7396,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  load_weights,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  output logic [DATA_WIDTH-1:0] weight_data,
  output logic [31:0]           weight_addr,
  output logic                  weight_we,
  output logic                  in_en,
  input  logic                  conv_o_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  import conv_ctrl_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(WEIGHT_BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(WEIGHT_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(OUT_PIXELS - 1);

  state_t                  state_reg, state_next;
  logic                    weights_loaded_reg;
  logic [ADDR_WIDTH-1:0]   widx_reg;
  logic [ADDR_WIDTH-1:0]   pix_cnt_reg;
  logic                    weight_we_reg;
  logic [ADDR_WIDTH-1:0]   weight_addr_reg;
  logic [DATA_WIDTH-1:0]   weight_data_reg;

  logic start_acc, beat_acc, last_beat, pix_hit, last_pix;
  logic enter_load, enter_run, timeout;

  assign start_acc = (state_reg == ST_IDLE) && start;
  assign beat_acc  = (state_reg == ST_LOAD) && host_valid;
  assign last_beat = beat_acc && (widx_reg == LAST_IDX);
  assign pix_hit   = (state_reg == ST_RUN) && conv_o_valid;
  assign last_pix  = pix_hit && (pix_cnt_reg == LAST_PIX);

  assign enter_load = (state_reg != ST_LOAD) && (state_next == ST_LOAD);
  assign enter_run  = (state_reg != ST_RUN)  && (state_next == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (load_weights || !weights_loaded_reg) ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (last_beat) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (last_pix)     state_next = ST_DONE;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Weight write port is registered so each write lands one cycle after its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_loaded_reg <= 1'b0;
      widx_reg           <= '0;
      weight_we_reg      <= 1'b0;
      weight_addr_reg    <= '0;
      weight_data_reg    <= '0;
    end else begin
      weight_we_reg <= beat_acc;
      if (beat_acc) begin
        weight_addr_reg <= BASE_ADDR + widx_reg;
        weight_data_reg <= host_data;
      end
      if (enter_load) begin
        widx_reg <= '0;
      end else if (beat_acc) begin
        widx_reg <= widx_reg + 1'b1;
      end
      if (last_beat) weights_loaded_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_reg <= '0;
    end else if (enter_run) begin
      pix_cnt_reg <= '0;
    end else if (pix_hit) begin
      pix_cnt_reg <= pix_cnt_reg + 1'b1;
    end
  end

`ifdef CONV_CTRL_WATCHDOG_EN
  logic error_reg;

  conv_ctrl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (enter_run),
    .active (state_reg == ST_RUN),
    .kick   (conv_o_valid),
    .timeout(timeout)
  );

  // Sticky until the host acknowledges by issuing the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_reg <= 1'b0;
    end else if (start_acc) begin
      error_reg <= 1'b0;
    end else if (timeout) begin
      error_reg <= 1'b1;
    end
  end

  assign error = error_reg;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  assign host_ready  = (state_reg == ST_LOAD);
  assign in_en       = (state_reg == ST_RUN);
  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);
  assign weight_we   = weight_we_reg;
  assign weight_addr = weight_addr_reg;
  assign weight_data = weight_data_reg;

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl with a small layer (4 weights, 6 pixels, timeout 20).
// The watchdog scenario follows CONV_CTRL_WATCHDOG_EN like the design.
module tb_conv_ctrl;

  localparam int DW   = 16;
  localparam int BASE = 23;
  localparam int WC   = 4;
  localparam int NPIX = 6;
  localparam int TMO  = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          load_weights = 1'b0;
  logic [DW-1:0] host_data = '0;
  logic          host_valid = 1'b0;
  logic          conv_o_valid = 1'b0;
  logic          host_ready, weight_we, in_en, busy, done, error;
  logic [DW-1:0] weight_data;
  logic [31:0]   weight_addr;

  int n_checks = 0;
  int n_fail = 0;
  int we_count = 0;
  int done_count = 0;
  logic [31:0]   addr_q[$];
  logic [DW-1:0] data_q[$];

  conv_ctrl #(
    .DATA_WIDTH      (DW),
    .WEIGHT_BASE_ADDR(BASE),
    .WEIGHT_COUNT    (WC),
    .OUT_PIXELS      (NPIX),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .load_weights(load_weights),
    .host_data   (host_data),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .weight_data (weight_data),
    .weight_addr (weight_addr),
    .weight_we   (weight_we),
    .in_en       (in_en),
    .conv_o_valid(conv_o_valid),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Write and done monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (weight_we === 1'b1) begin
      we_count++;
      addr_q.push_back(weight_addr);
      data_q.push_back(weight_data);
      $display("write addr=%0d data=0x%0h", weight_addr, weight_data);
    end
    if (done === 1'b1) done_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".outs"},
          {20'd0, host_ready, weight_we, in_en, busy, done, error, 6'd0}, 32'd0);
    check({tag, ".addr"}, weight_addr, 32'd0);
    check({tag, ".data"}, 32'(weight_data), 32'd0);
  endtask

  task automatic do_start(input logic lw);
    start = 1'b1;
    load_weights = lw;
    step();
    start = 1'b0;
    load_weights = 1'b0;
  endtask

  // Back-to-back load of WC beats starting at data value d0; LOAD already entered.
  task automatic load_b2b(input logic [DW-1:0] d0);
    for (int k = 0; k < WC; k++) begin
      host_data = d0 + DW'(k);
      host_valid = 1'b1;
      step();
      check($sformatf("b2b.we%0d", k), 32'(weight_we), 32'd1);
      check($sformatf("b2b.addr%0d", k), weight_addr, 32'(BASE + k));
      check($sformatf("b2b.data%0d", k), 32'(weight_data), 32'(d0) + 32'(k));
      check($sformatf("b2b.ready%0d", k), 32'(host_ready), (k == WC - 1) ? 32'd0 : 32'd1);
    end
    host_valid = 1'b0;
    check("b2b.in_en", 32'(in_en), 32'd1);
  endtask

  // Full frame of NPIX valids from RUN; checks DONE timing and return to IDLE.
  task automatic run_frame(input string tag);
    int d0;
    d0 = done_count;
    for (int i = 0; i < NPIX; i++) begin
      conv_o_valid = 1'b1;
      step();
      check($sformatf("%s.in_en%0d", tag, i), 32'(in_en), (i == NPIX - 1) ? 32'd0 : 32'd1);
      check($sformatf("%s.done%0d", tag, i), 32'(done), (i == NPIX - 1) ? 32'd1 : 32'd0);
    end
    conv_o_valid = 1'b0;
    step();
    check({tag, ".done_after"}, 32'(done), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".done_cycles"}, 32'(done_count - d0), 32'd1);
  endtask

  initial begin
    int w0;
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w0;
    // Reset state
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // First start after reset with load_weights=0 must still load
    do_start(1'b0);
    check("first_start.host_ready", 32'(host_ready), 32'd1);
    check("first_start.busy", 32'(busy), 32'd1);
    check("first_start.we", 32'(weight_we), 32'd0);
    load_b2b(16'h00A0);
    step();
    check("b2b.we_off", 32'(weight_we), 32'd0);
    run_frame("frame1");

    // Completed load: load_weights=0 goes straight to RUN without writes
    w0 = we_count;
    do_start(1'b0);
    check("direct_run.in_en", 32'(in_en), 32'd1);
    check("direct_run.host_ready", 32'(host_ready), 32'd0);
    run_frame("frame2");
    check("direct_run.no_writes", 32'(we_count - w0), 32'd0);

    // Stray valids in IDLE are ignored; gapped reload with start ignored in LOAD
    conv_o_valid = 1'b1;
    step(); step();
    conv_o_valid = 1'b0;
    check("idle_valid.busy", 32'(busy), 32'd0);
    addr_q.delete();
    data_q.delete();
    do_start(1'b1);
    for (int b = 0; b < 2 * WC - 1; b++) begin
      host_valid = (b % 2 == 0);
      host_data = 16'h00B0 + DW'(b / 2);
      start = (b == 1);
      step();
      check($sformatf("gap.we%0d", b), 32'(weight_we), (b % 2 == 0) ? 32'd1 : 32'd0);
    end
    host_valid = 1'b0;
    start = 1'b0;
    step();
    check("gap.count", 32'(addr_q.size()), 32'(WC));
    for (int k = 0; k < WC; k++) begin
      if (k < addr_q.size()) begin
        check($sformatf("gap.addr%0d", k), addr_q[k], 32'(BASE + k));
        check($sformatf("gap.data%0d", k), 32'(data_q[k]), 32'h00B0 + 32'(k));
      end
    end
    check("gap.in_en", 32'(in_en), 32'd1);
    run_frame("frame3");

    // Reset in the middle of a load
    do_start(1'b1);
    for (int k = 0; k < 2; k++) begin
      host_data = 16'h00C0 + DW'(k);
      host_valid = 1'b1;
      step();
    end
    check("midload.we_before", 32'(weight_we), 32'd1);
    w0 = we_count;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midload_rst");
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    host_valid = 1'b0;
    check("midload.no_writes", 32'(we_count - w0), 32'd0);
    check("midload.idle", 32'(busy), 32'd0);
    do_start(1'b0);
    check("midload.reload", 32'(host_ready), 32'd1);
    load_b2b(16'h00D0);

`ifdef CONV_CTRL_WATCHDOG_EN
    // Stall after 3 valids: error after 20 quiet cycles, no done
    w0 = done_count;
    conv_o_valid = 1'b1;
    step(); step(); step();
    conv_o_valid = 1'b0;
    for (int c = 0; c < TMO - 1; c++) step();
    check("wd.busy_before", 32'(busy), 32'd1);
    check("wd.error_before", 32'(error), 32'd0);
    step();
    check("wd.error", 32'(error), 32'd1);
    check("wd.idle", 32'(busy), 32'd0);
    check("wd.no_done", 32'(done_count - w0), 32'd0);
    step(); step();
    check("wd.sticky", 32'(error), 32'd1);
    do_start(1'b0);
    check("wd.error_cleared", 32'(error), 32'd0);
    check("wd.rerun", 32'(in_en), 32'd1);
    run_frame("frame_wd");
`else
    // Without the watchdog RUN waits indefinitely
    conv_o_valid = 1'b1;
    step(); step(); step();
    conv_o_valid = 1'b0;
    for (int c = 0; c < 2 * TMO; c++) step();
    check("nowd.error", 32'(error), 32'd0);
    check("nowd.in_en", 32'(in_en), 32'd1);
    w0 = done_count;
    conv_o_valid = 1'b1;
    step(); step(); step();
    conv_o_valid = 1'b0;
    check("nowd.done", 32'(done), 32'd1);
    step();
    check("nowd.done_cycles", 32'(done_count - w0), 32'd1);
    check("nowd.idle", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of one weight word.
REQ-002 SHALL have parameter WEIGHT_BASE_ADDR, default 23, meaning the first weight address of the layer.
REQ-003 SHALL have parameter WEIGHT_COUNT, default 224, meaning the number of weight words per layer load.
REQ-004 SHALL have parameter OUT_PIXELS, default 7396, meaning the number of output pixels per frame.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the watchdog limit in cycles.
REQ-006 SHALL have port clk, input, width 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, width 1: asynchronous reset, active-low.
REQ-008 SHALL have port start, input, width 1: frame request pulse.
REQ-009 SHALL have port load_weights, input, width 1: sampled with start; 1 requests a weight load before the run.
REQ-010 SHALL have port host_data, input, width DATA_WIDTH: weight word from host.
REQ-011 SHALL have port host_valid, input, width 1: host_data valid.
REQ-012 SHALL have port host_ready, output, width 1: weight word accepted when host_valid and host_ready are both high.
REQ-013 SHALL have ports weight_data (output, width DATA_WIDTH), weight_addr (output, width 32) and weight_we (output, width 1): weight write port to the conv layer.
REQ-014 SHALL have port in_en, output, width 1: enables the conv input FIFO path.
REQ-015 SHALL have port conv_o_valid, input, width 1: conv output pixel strobe.
REQ-016 SHALL have ports busy (output, width 1), done (output, width 1) and error (output, width 1).

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN and DONE.
REQ-018 IDLE: start with load_weights=1 SHALL go to LOAD.
REQ-019 IDLE: start with load_weights=0 SHALL go to RUN when weights_loaded=1, otherwise to LOAD.
REQ-020 IDLE: without start, the FSM SHALL stay in IDLE.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 LOAD: host_ready SHALL be 1 and no other state SHALL assert host_ready.
REQ-023 LOAD: each accepted beat k (0-based) SHALL produce, one cycle later, registered weight_we=1, weight_addr=WEIGHT_BASE_ADDR+k and weight_data equal to that beat's host_data.
REQ-024 LOAD: after beat WEIGHT_COUNT-1 is accepted, the FSM SHALL set weights_loaded, deassert host_ready on the next cycle and enter RUN.
REQ-025 Host gaps (host_valid=0) SHALL stall the load without any write.
REQ-026 RUN: in_en SHALL be 1 in RUN only.
REQ-027 RUN: the 32-bit pixel counter SHALL increment on each conv_o_valid.
REQ-028 RUN: when the OUT_PIXELS-th valid is counted, the FSM SHALL enter DONE and deassert in_en on the next cycle.
REQ-029 conv_o_valid outside RUN SHALL be ignored.
REQ-030 DONE SHALL last exactly one cycle, assert done=1 and return to IDLE.
REQ-031 busy SHALL be 1 in LOAD, RUN and DONE, and 0 in IDLE.
REQ-032 The pixel counter SHALL clear when RUN is entered.
REQ-033 The weight index SHALL clear when LOAD is entered.
REQ-034 Counters SHALL not wrap within one frame.

Reset
REQ-035 rst_n low SHALL asynchronously force state IDLE, weights_loaded=0, both counters 0 and every output to 0 (host_ready, weight_we, weight_addr, weight_data, in_en, busy, done, error).
REQ-036 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation, and no further weight_we SHALL be issued.
REQ-037 After reset release, the first accepted start SHALL always go through LOAD.

Configuration
REQ-038 With macro CONV_CTRL_WATCHDOG_EN defined: in RUN, a cycle counter SHALL reset on each conv_o_valid and on RUN entry.
REQ-039 With CONV_CTRL_WATCHDOG_EN defined: after TIMEOUT_CYCLES consecutive cycles without conv_o_valid, error SHALL be set (sticky) and the FSM SHALL go to IDLE without pulsing done.
REQ-040 With CONV_CTRL_WATCHDOG_EN defined: error SHALL clear on the next accepted start.
REQ-041 Without CONV_CTRL_WATCHDOG_EN: no watchdog logic SHALL exist, error SHALL be tied to 0 and RUN SHALL wait indefinitely.

Structure
REQ-042 A shared package conv_ctrl_pkg SHALL hold the state encoding constants and the 32-bit address width constant.
REQ-043 The watchdog SHALL be the sub-module conv_ctrl_watchdog, instantiated only under CONV_CTRL_WATCHDOG_EN.

Verification (WEIGHT_BASE_ADDR=23, WEIGHT_COUNT=4, OUT_PIXELS=6, TIMEOUT_CYCLES=20)
REQ-044 Test: start with load_weights=1 and 4 back-to-back beats 0xA0..0xA3 -> weight_we at addresses 23..26 with the same data, each one cycle after acceptance, then in_en=1.
REQ-045 Test: host_valid toggling 1,0,1,0 -> writes only on accepted beats, with addresses contiguous 23..26.
REQ-046 Test: 6 conv_o_valid pulses in RUN -> done high for exactly 1 cycle, in_en low the cycle after the 6th valid, busy=0 afterward.
REQ-047 Test: start with load_weights=0 after reset -> FSM goes to LOAD; start with load_weights=0 after a completed load -> RUN directly with no weight_we.
REQ-048 Test: rst_n asserted after 2 of 4 beats -> all outputs 0 immediately and no further weight_we; the next start requires a reload.
REQ-049 Test (watchdog enabled): 3 valids then 20 idle cycles -> error=1, state IDLE, no done pulse; error clears on the next start.
